vco_edge_counter: RTL and testbench

- Receive-side digitizer for the behavioural VCO: drives the VCO's active-low enable and takes in its 1-bit phase output.
- Synchronizes the phase output into the system clock domain and counts its rising edges over a programmable window of clock cycles.
- Emits one count per window over a valid/ready interface to the downstream decimation/filter logic.
- Sits between the VCO macro and the ADC back-end.

---
 rtl/vco_adc_pkg.sv | 17 +
 rtl/vco_sync_edge.sv | 33 +++
 rtl/vco_edge_counter.sv | 158 +++++++++++++++
 tb/tb_vco_edge_counter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vco_adc_pkg.sv
// Shared types and defaults for the VCO receive-side digitizer.
// Holds the conversion FSM state type and the VCO enable polarity.
package vco_adc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StRun
  } state_e;

  localparam int unsigned CNT_W_DEF = 10;
  localparam int unsigned WIN_W_DEF = 10;

  localparam logic VCO_ENB_ON  = 1'b0;
  localparam logic VCO_ENB_OFF = 1'b1;

endpackage

// File: rtl/vco_sync_edge.sv
// Two-flop synchronizer for the asynchronous VCO phase plus registered rising-edge detect.
// Runs in every state, so the count starts from a settled history on entry to RUN.
module vco_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vco_p,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic rise_d, rise_q;

  always_comb begin
    rise_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= vco_p;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/vco_edge_counter.sv
// Enables the VCO, counts synchronized phase rising edges over a programmable window,
// and hands one count per window downstream over a valid/ready register.
module vco_edge_counter
  import vco_adc_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WIN_W      = WIN_W_DEF,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] win_len,
  input  logic             vco_p,
  output logic             vco_enb,
  output logic [CNT_W-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy
);

  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             vco_enb_q, vco_enb_d;
  logic             busy_q, busy_d;

  logic             rise;
  logic             win_end;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_sat;

  vco_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .vco_p(vco_p),
    .rise (rise)
  );

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    vco_enb_d = vco_enb_q;
    busy_d    = busy_q;
    win_end   = 1'b0;

    cnt_sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rise};
    cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_d     = (win_len == '0) ? WIN_ONE : win_len;
          overrun_d = 1'b0;
          settle_d  = '0;
          state_d   = StSettle;
          vco_enb_d = VCO_ENB_ON;
          busy_d    = 1'b1;
        end
      end
      StSettle: begin
        if (stop) begin
          state_d   = StIdle;
          vco_enb_d = VCO_ENB_OFF;
          busy_d    = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = StRun;
          cnt_d   = '0;
          wcnt_d  = win_q;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StRun: begin
        // A stop in the terminal cycle still lets this window complete and deliver.
        if (wcnt_q == WIN_ONE) begin
          win_end = 1'b1;
          cnt_d   = '0;
          wcnt_d  = win_q;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
          cnt_d  = cnt_sat;
        end
        if (stop) begin
          state_d   = StIdle;
          vco_enb_d = VCO_ENB_OFF;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        vco_enb_d = VCO_ENB_OFF;
        busy_d    = 1'b0;
      end
    endcase

    if (win_end && (!valid_q || sample_ready)) begin
      sample_d = cnt_sat;
      valid_d  = 1'b1;
    end else begin
      if (win_end) begin
        overrun_d = 1'b1;
      end
      if (valid_q && sample_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      win_q     <= '0;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      vco_enb_q <= VCO_ENB_OFF;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      win_q     <= win_d;
      wcnt_q    <= wcnt_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      vco_enb_q <= vco_enb_d;
      busy_q    <= busy_d;
    end
  end

  assign vco_enb      = vco_enb_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vco_edge_counter.sv
// Directed bench for vco_edge_counter: a default-width instance plus a 4-bit count instance
// sharing all inputs; VCO phase comes from a square-wave / scripted-pulse generator.
module tb_vco_edge_counter;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned WIN_W = 10;

  logic             clk, rst, start, stop, vco_p, sample_ready;
  logic [WIN_W-1:0] win_len;
  logic             vco_enb, sample_valid, overrun, busy;
  logic [CNT_W-1:0] sample;
  logic             s_vco_enb, s_valid, s_overrun, s_busy;
  logic [3:0]       s_sample;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vco_mode = 0;
  int vco_half = 1;
  int ph = 0;
  int pat_t0 = 0;

  vco_edge_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .win_len     (win_len),
    .vco_p       (vco_p),
    .vco_enb     (vco_enb),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  vco_edge_counter #(.CNT_W(4), .WIN_W(WIN_W), .SETTLE_CYC(16)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .win_len     (win_len),
    .vco_p       (vco_p),
    .vco_enb     (s_vco_enb),
    .sample      (s_sample),
    .sample_valid(s_valid),
    .sample_ready(sample_ready),
    .overrun     (s_overrun),
    .busy        (s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Phase generator: updates 1 time unit after each falling edge.
  // Mode 2 pulses high for 2 cycles at rel 18+10w and 23+10w (w=0..9), so rise lands
  // mid-window and in the terminal cycle of every 10-cycle window.
  initial begin
    int rel;
    vco_p = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      case (vco_mode)
        1: begin
          ph++;
          if (ph >= vco_half) begin
            ph = 0;
            vco_p = ~vco_p;
          end
        end
        2: begin
          rel = cyc - pat_t0;
          vco_p = (rel >= 18 && rel <= 114 &&
                   ((rel - 18) % 10 == 0 || (rel - 18) % 10 == 1 ||
                    (rel - 18) % 10 == 5 || (rel - 18) % 10 == 6));
        end
        default: vco_p = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!sample_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!sample_valid) n = -1;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    sample_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    sample_ready = 1'b0;
    win_len = '0;
    repeat (3) tick();
    n_cmp++;
    if ({vco_enb, busy, sample_valid, overrun} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags: got enb/busy/valid/ovr=%b want 1000",
               {vco_enb, busy, sample_valid, overrun});
    end
    n_cmp++;
    if (sample !== '0 || s_sample !== '0) begin
      n_bad++;
      $display("FAIL reset_sample: got %0d/%0d want 0/0", sample, s_sample);
    end
    n_cmp++;
    if ({s_vco_enb, s_busy, s_valid, s_overrun} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_sat_flags: got %b want 1000", {s_vco_enb, s_busy, s_valid, s_overrun});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_counting();
    int n;
    vco_mode = 1;
    vco_half = 4;
    sample_ready = 1'b1;
    win_len = 10'd64;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (vco_enb !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL count_enable: got enb=%b busy=%b want 0 1", vco_enb, busy);
    end
    wait_valid(200, n);
    n_cmp++;
    if (n + 1 != 81) begin
      n_bad++;
      $display("FAIL count_first_latency: got %0d cycles want 81", n + 1);
    end
    n_cmp++;
    if (sample !== 10'd8) begin
      n_bad++;
      $display("FAIL count_first_value: got %0d want 8", sample);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_valid(100, n);
      n_cmp++;
      if (n != 63 || sample !== 10'd8) begin
        n_bad++;
        $display("FAIL count_window%0d: got gap=%0d value=%0d want 63 8", k, n, sample);
      end
      tick();
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL count_overrun: got %b want 0", overrun);
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    int n;
    int bad_stable;
    vco_mode = 1;
    vco_half = 2;
    sample_ready = 1'b0;
    win_len = 10'd32;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(100, n);
    n_cmp++;
    if (n != 48 || sample !== 10'd8 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_first: got n=%0d value=%0d ovr=%b want 48 8 0", n, sample, overrun);
    end
    bad_stable = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (sample_valid !== 1'b1 || sample !== 10'd8) bad_stable++;
    end
    n_cmp++;
    if (bad_stable != 0) begin
      n_bad++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_stable);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_overrun: got %b want 1", overrun);
    end
    sample_ready = 1'b1;
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_single_accept: got valid=%b want 0", sample_valid);
    end
    wait_valid(40, n);
    n_cmp++;
    if (n != 25 || sample !== 10'd8 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_next: got n=%0d value=%0d ovr=%b want 25 8 1", n, sample, overrun);
    end
    go_idle();
  endtask

  task automatic test_saturation();
    int n;
    vco_mode = 1;
    vco_half = 1;
    sample_ready = 1'b1;
    win_len = 10'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_valid(200, n);
      n_cmp++;
      if (s_valid !== 1'b1 || s_sample !== 4'd15) begin
        n_bad++;
        $display("FAIL sat_window%0d: got valid=%b value=%0d want 1 15", k, s_valid, s_sample);
      end
      n_cmp++;
      if (sample !== 10'd50) begin
        n_bad++;
        $display("FAIL sat_wide%0d: got %0d want 50", k, sample);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_boundary();
    int n;
    int sum;
    vco_mode = 2;
    pat_t0 = cyc + 1;
    sample_ready = 1'b1;
    win_len = 10'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    sum = 0;
    for (int w = 0; w < 10; w++) begin
      wait_valid(30, n);
      n_cmp++;
      if (n < 0 || sample !== 10'd2) begin
        n_bad++;
        $display("FAIL boundary_window%0d: got n=%0d value=%0d want 2", w, n, sample);
      end
      sum += int'(sample);
      tick();
    end
    n_cmp++;
    if (sum != 20) begin
      n_bad++;
      $display("FAIL boundary_sum: got %0d want 20", sum);
    end
    vco_mode = 0;
    go_idle();
  endtask

  task automatic test_abort();
    int n;
    vco_mode = 1;
    vco_half = 4;
    sample_ready = 1'b0;
    win_len = 10'd64;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(200, n);
    repeat (20) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (vco_enb !== 1'b1 || busy !== 1'b0 || sample_valid !== 1'b1 || sample !== 10'd8) begin
      n_bad++;
      $display("FAIL abort_stop: got enb=%b busy=%b valid=%b value=%0d want 1 0 1 8",
               vco_enb, busy, sample_valid, sample);
    end
    repeat (80) tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample !== 10'd8 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_retain: got valid=%b value=%0d ovr=%b want 1 8 0",
               sample_valid, sample, overrun);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    n_cmp++;
    if (busy !== 1'b1 || vco_enb !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_rerun: got busy=%b enb=%b want 1 0", busy, vco_enb);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({vco_enb, busy, sample_valid, overrun} !== 4'b1000 || sample !== '0 ||
        {s_vco_enb, s_busy, s_valid, s_overrun} !== 4'b1000) begin
      n_bad++;
      $display("FAIL abort_reset: got enb/busy/valid/ovr=%b sample=%0d want 1000 0",
               {vco_enb, busy, sample_valid, overrun}, sample);
    end
    rst = 1'b0;
    tick();
    // Stop landing in the terminal cycle: window still delivered.
    sample_ready = 1'b1;
    win_len = 10'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (31) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (sample_valid !== 1'b1 || sample !== 10'd2 || busy !== 1'b0 || vco_enb !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_terminal: got valid=%b value=%0d busy=%b enb=%b want 1 2 0 1",
               sample_valid, sample, busy, vco_enb);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_terminal_drain: got valid=%b want 0", sample_valid);
    end
    vco_mode = 0;
    go_idle();
  endtask

  task automatic test_win_zero();
    int n;
    int bad;
    vco_mode = 0;
    sample_ready = 1'b1;
    win_len = '0;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wz_start_wins: got busy=%b want 1", busy);
    end
    wait_valid(40, n);
    n_cmp++;
    if (n != 17) begin
      n_bad++;
      $display("FAIL wz_latency: got %0d want 17", n);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sample_valid !== 1'b1 || sample !== '0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL wz_every_cycle: got %0d bad cycles want 0", bad);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_counting();
    test_backpressure();
    test_saturation();
    test_boundary();
    test_abort();
    test_win_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
